// File: rtl/fsm_input_conditioner.sv
// Key conditioner for the lab FSMs: synchroniser, debounce counter and enable-strobe divider.
// Optional registered edge pulses on a_rise/a_fall are built only when FSM_IN_EDGE_EN is defined.
module fsm_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STROBE_DIV      = 25000000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic a,
    output logic en,
    output logic a_rise,
    output logic a_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam logic KEY_IDLE = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STROBE_DIV - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("fsm_input_conditioner: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("fsm_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
        end
        if (STROBE_DIV < 1) begin : g_bad_div
            $error("fsm_input_conditioner: STROBE_DIV must be >= 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [DIV_W-1:0]       r_div;
    logic                   r_a;
    logic                   r_en;
    logic                   w_key_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{KEY_IDLE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw};
        end
    end

    // Normalise to active-high so the debouncer only ever deals with "pressed = 1".
    assign w_key_s = r_sync[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_a   <= 1'b0;
        end else if (w_key_s == r_a) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_a   <= w_key_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_en  <= 1'b0;
        end else begin
            r_en  <= (r_div == DIV_LAST);
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign a  = r_a;
    assign en = r_en;

`ifdef FSM_IN_EDGE_EN
    logic r_a_q;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_q  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_a_q  <= r_a;
            r_rise <= r_a & ~r_a_q;
            r_fall <= ~r_a & r_a_q;
        end
    end

    assign a_rise = r_rise;
    assign a_fall = r_fall;
`else
    assign a_rise = 1'b0;
    assign a_fall = 1'b0;
`endif

endmodule
